fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage sitting directly upstream of the IF/ID register of the ARM pipeline. Generates the fetch PC, drives a 1-cycle-latency instruction memory, buffers returned words in a small queue so decode stalls never lose an in-flight fetch, and redirects on taken branches. Detects the all-zero end-of-program word and stops fetching so the bench's completion check sees a clean halt.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- DEPTH, 2, instruction queue entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- imem_req  out  1  fetch request this cycle
- imem_addr  out  32  byte address of requested word, bits [1:0] always 0
- imem_rdata  in  32  instruction word, valid exactly one cycle after imem_req
- stall_in  in  1  hazard unit holds IF/ID; head entry not consumed
- branch_taken  in  1  redirect request from EX
- branch_target  in  32  redirect address
- instr_out  out  32  head-of-queue instruction
- instr_pc  out  32  byte address of instr_out
- valid_out  out  1  instr_out/instr_pc valid
- PC_out  out  32  next fetch PC
- halted  out  1  sticky: zero word fetched, fetch suspended

## Operation
- Reset (reset=0): PC_out=RESET_PC, queue empty, valid_out=0, instr_out=0, instr_pc=0, imem_req=0, halted=0, in-flight flag cleared.
- pop = valid_out & ~stall_in. Head consumed on pop.
- issue = ~halted & (count − pop + inflight < DEPTH). On issue: imem_req=1, imem_addr=PC_out, PC_out←PC_out+4 (wraps modulo 2^32). inflight←issue.
- Response: when inflight=1 and not killed, {imem_rdata, addr} pushed to queue tail at end of that cycle.
- Push and pop in same cycle allowed at any occupancy; count unchanged.
- Zero word: pushing imem_rdata==32'h0 sets halted. The zero word itself is queued and presented normally; later fetches not issued. Request already in flight when halted sets is killed.
- Branch (branch_taken=1): queue flushed, pending response killed, halted cleared, imem_req=1 with imem_addr={branch_target[31:2],2'b00}, PC_out←that+4. Overrides stall_in, halt and issue rule.
- Branch and zero-word response in same cycle: branch wins, halted stays 0.
- Queue never overflows; overflow is a design error (assertion).

## Timing
- Fetch latency: request cycle N, data in queue end of N+1, valid_out from N+2.
- Steady state, no stall: one instruction per cycle on valid_out.
- stall_in held k cycles: at most DEPTH words buffered, imem_req deasserts once buffer+inflight full; resume on stall release with no bubble beyond queue refill.
- Branch in cycle B: target instruction valid_out at B+2; valid_out=0 in B+1.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), in-flight response discarded.
- First request issued in first cycle after reset deassertion.

## Structure
- Shared package/include fetch_defs: RESET_PC default, INSTR_W=32, HALT_WORD=32'h0, word-align mask.
- One sub-module: fetch_queue — DEPTH-entry synchronous FIFO of {pc[31:0], instr[31:0]}, push/pop/flush, count, same-cycle push+pop, asynchronous active-low reset.
- Top holds PC register, inflight/kill flags, halted flag, issue logic.

## Test plan
- Sequential run: imem returns 0xE3A01005, 0xE3A02003, 0xE0813002 at 0,4,8 -> valid_out on cycles 2,3,4 with instr_pc 0,4,8, PC_out reaches 12 by cycle 3.
- Stall: stall_in=1 for 3 cycles with queue half full -> queue fills to 2, imem_req drops, no word lost or duplicated; order preserved after release.
- Branch: branch_taken with target 0x0000_0042 while 2 words queued -> queue flushed, imem_addr=0x40, next valid instr_pc=0x40 two cycles later, stale response dropped.
- Halt: word 0 returned at address 0x1C -> halted=1, instr_out=0 presented at 0x1C, no imem_req afterward; later branch to 0x08 clears halted and fetches 0x08.
- Branch with stall_in=1 same cycle -> redirect taken; PC wrap: branch to 0xFFFF_FFFC -> next fetch address 0x0000_0000.
- Reset pulse mid-stream with response in flight -> all outputs reset, first post-reset request at RESET_PC, old response never appears.

Source files
------------

// File: rtl/fetch_defs_pkg.sv
// Shared fetch-stage definitions: reset vector, word width, halt word,
// word alignment helper and the queue entry layout.
package fetch_defs_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr} with flush and same-cycle push+pop.
// Head entry is visible combinationally so decode sees it the cycle it lands.
module fetch_queue
  import fetch_defs_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [31:0]        push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic               head_valid,
  output logic [31:0]        head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;
  fq_entry_t        entry_arr [DEPTH];

  // Flush wins over everything; popping an empty queue is ignored.
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      fq_entry_t entry_reg;

      always_ff @(posedge clk) begin
        if (do_push && (tail_reg == PTR_W'(gi))) begin
          entry_reg <= '{pc: push_pc, instr: push_instr};
        end
      end

      assign entry_arr[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + PTR_W'(1);
      if (do_pop)  head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != '0);
  assign head_pc    = entry_arr[head_reg].pc;
  assign head_instr = entry_arr[head_reg].instr;

  overflow_check: assert property (@(posedge clk) disable iff (!reset)
    !(do_push && !do_pop && (count_reg == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, 1-cycle imem handshake, response queue,
// branch redirect and halt on the all-zero end-of-program word.
module fetch_unit
  import fetch_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_in,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [INSTR_W-1:0] instr_out,
  output logic [31:0]        instr_pc,
  output logic               valid_out,
  output logic [31:0]        PC_out,
  output logic               halted
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]        pc_reg, pc_next;
  logic               inflight_reg, inflight_next;
  logic [31:0]        inflight_pc_reg, inflight_pc_next;
  logic               halted_reg, halted_next;
  logic               req_c;
  logic [31:0]        addr_c;
  logic [31:0]        branch_pc;
  logic               pop, push, issue;
  logic [CNT_W:0]     occ;
  logic [CNT_W-1:0]   q_count;
  logic               q_valid;
  logic [31:0]        q_pc;
  logic [INSTR_W-1:0] q_instr;

  assign branch_pc = word_align(branch_target);
  assign pop       = q_valid & ~stall_in;
  // A response is dropped when a redirect flushes it or fetch already halted.
  assign push      = inflight_reg & ~branch_taken & ~halted_reg;
  // Occupancy after this cycle if the in-flight word lands: must leave a slot.
  assign occ       = {1'b0, q_count} + (CNT_W + 1)'(inflight_reg) - (CNT_W + 1)'(pop);
  assign issue     = ~halted_reg & (occ < (CNT_W + 1)'(DEPTH));

  always_comb begin
    pc_next          = pc_reg;
    inflight_next    = 1'b0;
    inflight_pc_next = inflight_pc_reg;
    halted_next      = halted_reg;
    req_c            = 1'b0;
    addr_c           = pc_reg;
    if (branch_taken) begin
      req_c            = 1'b1;
      addr_c           = branch_pc;
      pc_next          = branch_pc + 32'd4;
      inflight_next    = 1'b1;
      inflight_pc_next = branch_pc;
      halted_next      = 1'b0;
    end else begin
      if (issue) begin
        req_c            = 1'b1;
        pc_next          = pc_reg + 32'd4;
        inflight_next    = 1'b1;
        inflight_pc_next = pc_reg;
      end
      if (push && (imem_rdata == HALT_WORD)) begin
        halted_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg          <= word_align(RESET_PC);
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      halted_reg      <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      halted_reg      <= halted_next;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_pc    (inflight_pc_reg),
    .push_instr (imem_rdata),
    .pop        (pop),
    .flush      (branch_taken),
    .count      (q_count),
    .head_valid (q_valid),
    .head_pc    (q_pc),
    .head_instr (q_instr)
  );

  // Requests are held off while reset is asserted.
  assign imem_req  = reset & req_c;
  assign imem_addr = addr_c;
  assign valid_out = q_valid;
  assign instr_out = q_valid ? q_instr : '0;
  assign instr_pc  = q_valid ? q_pc : '0;
  assign PC_out    = pc_reg;
  assign halted    = halted_reg;

endmodule
